// File: rtl/t_ff_counter.sv
// Modulo-MODULUS up/down counter built from T flip-flops with per-stage toggle enables.
// Define T_FF_COUNTER_SAT_EN to hold at the terminal count instead of wrapping.
module t_ff_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic             out_of_range;
  logic             terminal;
  logic             and_chain;
  logic             nor_chain;
  logic [WIDTH-1:0] din_clamped;
  logic [WIDTH-1:0] natural_t;

  // A full-range modulus cannot go out of range, so the compares are elided there.
  generate
    if (MODULUS >= (1 << WIDTH)) begin : g_full_range
      assign out_of_range = 1'b0;
      assign din_clamped  = din;
    end else begin : g_partial_range
      assign out_of_range = (q > MAX);
      assign din_clamped  = (din > MAX) ? MAX : din;
    end
  endgenerate

  always_comb begin
    and_chain = 1'b1;
    nor_chain = 1'b1;
    natural_t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      natural_t[i] = up ? and_chain : nor_chain;
      and_chain    = and_chain & q[i];
      nor_chain    = nor_chain & ~q[i];
    end
  end

  assign terminal = up ? (q == MAX) : (q == '0);
  assign tc       = enable & ~load & terminal;

  // An out-of-range count toggles every set bit, which lands on zero.
  always_comb begin
    t_vec = natural_t;
    if (load) begin
      t_vec = q ^ din_clamped;
    end else if (!enable) begin
      t_vec = '0;
    end else if (out_of_range) begin
      t_vec = q;
    end else if (terminal) begin
`ifdef T_FF_COUNTER_SAT_EN
      t_vec = '0;
`else
      t_vec = q ^ (up ? {WIDTH{1'b0}} : MAX);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      q <= q ^ t_vec;
    end
  end

`ifdef T_FF_COUNTER_SAT_EN
  assign wrap = 1'b0;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end
`endif

endmodule

// File: tb/tb_t_ff_counter.sv
// Self-checking bench for t_ff_counter (MODULUS=10) against an arithmetic count model.
module tb_t_ff_counter;

  localparam int W = 4;
  localparam int M = 10;
`ifdef T_FF_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         enable;
  logic         up;
  logic         load;
  logic [W-1:0] din;
  logic [W-1:0] q;
  logic [W-1:0] t_vec;
  logic         tc;
  logic         wrap;

  int checks;
  int passed;
  int m_q;
  bit m_wrap;

  t_ff_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .din(din), .q(q), .t_vec(t_vec), .tc(tc), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int next_count(int cur, bit en, bit u, bit ld, int d);
    if (ld) return (d > M - 1) ? M - 1 : d;
    if (!en) return cur;
    if (cur > M - 1) return 0;
    if (u) begin
      if (cur == M - 1) return SAT ? cur : 0;
      return cur + 1;
    end
    if (cur == 0) return SAT ? cur : M - 1;
    return cur - 1;
  endfunction

  function automatic bit model_tc(int cur, bit en, bit u, bit ld);
    return en && !ld && (u ? (cur == M - 1) : (cur == 0));
  endfunction

  // Advances the model alongside one DUT clock edge using the inputs currently applied.
  task automatic tick();
    int nxt;
    bit w;
    nxt = next_count(m_q, enable, up, load, int'(din));
    w   = model_tc(m_q, enable, up, load) && !SAT;
    @(posedge clk);
    #1;
    m_q    = nxt;
    m_wrap = w;
  endtask

  task automatic drive(bit en, bit u, bit ld, int d);
    enable = en;
    up     = u;
    load   = ld;
    din    = W'(d);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 1, 0, 0);
    #11;
    checks++; if (q !== 4'd0) $display("[TB] FAIL reset_q got %0d expected 0", q); else passed++;
    checks++; if (wrap !== 1'b0) $display("[TB] FAIL reset_wrap got %0b expected 0", wrap); else passed++;
    checks++; if (t_vec !== 4'd0) $display("[TB] FAIL reset_tvec got %b expected 0000", t_vec); else passed++;
    checks++; if (tc !== 1'b0) $display("[TB] FAIL reset_tc got %0b expected 0", tc); else passed++;
    @(negedge clk);
    reset  = 1'b1;
    m_q    = 0;
    m_wrap = 1'b0;
    drive(0, 1, 1, 9);
    tick();
    checks++; if (q !== 4'd9) $display("[TB] FAIL preload_q got %0d expected 9", q); else passed++;
    drive(0, 1, 0, 0);
    #1;
    reset = 1'b0;
    #1;
    checks++; if (q !== 4'd0) $display("[TB] FAIL async_reset_q got %0d expected 0", q); else passed++;
    checks++; if (wrap !== 1'b0) $display("[TB] FAIL async_reset_wrap got %0b expected 0", wrap); else passed++;
    m_q    = 0;
    m_wrap = 1'b0;
    #1;
    reset = 1'b1;
    drive(1, 1, 0, 0);
    tick();
    checks++; if (q !== 4'd1) $display("[TB] FAIL release_first_count got %0d expected 1", q); else passed++;
  endtask

  task automatic test_up_wrap();
    drive(0, 1, 1, 0);
    tick();
    drive(1, 1, 0, 0);
    for (int i = 0; i < M - 1; i++) tick();
    checks++; if (q !== 4'd9) $display("[TB] FAIL up_reach_9 got %0d expected 9", q); else passed++;
    checks++; if (tc !== 1'b1) $display("[TB] FAIL up_tc got %0b expected 1", tc); else passed++;
    tick();
    checks++; if (q !== W'(m_q)) $display("[TB] FAIL up_wrap_q got %0d expected %0d", q, m_q); else passed++;
    checks++; if (wrap !== m_wrap) $display("[TB] FAIL up_wrap_pulse got %0b expected %0b", wrap, m_wrap); else passed++;
    tick();
    checks++; if (q !== W'(m_q)) $display("[TB] FAIL up_after_wrap_q got %0d expected %0d", q, m_q); else passed++;
    checks++; if (wrap !== 1'b0) $display("[TB] FAIL up_wrap_one_cycle got %0b expected 0", wrap); else passed++;
  endtask

  task automatic test_down_wrap();
    drive(0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0);
    checks++; if (tc !== 1'b1) $display("[TB] FAIL down_tc got %0b expected 1", tc); else passed++;
    checks++; if (t_vec !== (SAT ? 4'b0000 : 4'b1001)) $display("[TB] FAIL down_tvec got %b expected %b", t_vec, SAT ? 4'b0000 : 4'b1001); else passed++;
    tick();
    checks++; if (q !== W'(m_q)) $display("[TB] FAIL down_wrap_q got %0d expected %0d", q, m_q); else passed++;
    checks++; if (wrap !== m_wrap) $display("[TB] FAIL down_wrap_pulse got %0b expected %0b", wrap, m_wrap); else passed++;
    tick();
    checks++; if (wrap !== 1'b0) $display("[TB] FAIL down_wrap_one_cycle got %0b expected 0", wrap); else passed++;
  endtask

  task automatic test_load_priority();
    drive(0, 1, 1, 9);
    tick();
    drive(1, 1, 1, 5);
    checks++; if (tc !== 1'b0) $display("[TB] FAIL load_masks_tc got %0b expected 0", tc); else passed++;
    tick();
    checks++; if (q !== 4'd5) $display("[TB] FAIL load_wins_q got %0d expected 5", q); else passed++;
    checks++; if (wrap !== 1'b0) $display("[TB] FAIL load_no_wrap got %0b expected 0", wrap); else passed++;
    drive(1, 1, 1, 15);
    tick();
    checks++; if (q !== 4'd9) $display("[TB] FAIL load_clamp got %0d expected 9", q); else passed++;
  endtask

  task automatic test_toggle_vector();
    drive(0, 1, 1, 7);
    tick();
    drive(1, 1, 0, 0);
    checks++; if (t_vec !== 4'b1111) $display("[TB] FAIL tvec_carry got %b expected 1111", t_vec); else passed++;
    tick();
    checks++; if (q !== 4'd8) $display("[TB] FAIL tvec_carry_q got %0d expected 8", q); else passed++;
    drive(0, 1, 0, 0);
    checks++; if (t_vec !== 4'b0000) $display("[TB] FAIL tvec_disabled got %b expected 0000", t_vec); else passed++;
    tick();
    checks++; if (q !== 4'd8) $display("[TB] FAIL hold_q got %0d expected 8", q); else passed++;
  endtask

  task automatic test_terminal_hold();
    drive(0, 1, 1, 9);
    tick();
    drive(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (tc !== model_tc(m_q, 1, 1, 0)) $display("[TB] FAIL term_tc[%0d] got %0b expected %0b", i, tc, model_tc(m_q, 1, 1, 0)); else passed++;
      tick();
      checks++; if (q !== W'(m_q)) $display("[TB] FAIL term_q[%0d] got %0d expected %0d", i, q, m_q); else passed++;
      checks++; if (wrap !== m_wrap) $display("[TB] FAIL term_wrap[%0d] got %0b expected %0b", i, wrap, m_wrap); else passed++;
    end
  endtask

  task automatic test_random();
    int exp_next;
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));
      exp_next = next_count(m_q, enable, up, load, int'(din));
      checks++; if (t_vec !== W'(m_q ^ exp_next)) $display("[TB] FAIL rand_tvec[%0d] got %b expected %b", i, t_vec, W'(m_q ^ exp_next)); else passed++;
      checks++; if (tc !== model_tc(m_q, enable, up, load)) $display("[TB] FAIL rand_tc[%0d] got %0b expected %0b", i, tc, model_tc(m_q, enable, up, load)); else passed++;
      tick();
      checks++; if (q !== W'(m_q)) $display("[TB] FAIL rand_q[%0d] got %0d expected %0d", i, q, m_q); else passed++;
      checks++; if (wrap !== m_wrap) $display("[TB] FAIL rand_wrap[%0d] got %0b expected %0b", i, wrap, m_wrap); else passed++;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    m_q    = 0;
    m_wrap = 1'b0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
    test_toggle_vector();
    test_terminal_hold();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
